// File: rtl/mealy_nonlap_11011_detector.sv
// mealy_nonlap_11011_detector: flags non-overlapping 11011 occurrences on a serial bit stream
module mealy_nonlap_11011_detector (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic y
);
  typedef enum logic [2:0] {S0, S1, S2, S3, S4} state_t;
  state_t state_q, state_d;
  // next prefix state and Mealy strobe; a hit restarts from S0 so no bit is reused
  always_comb begin
    state_d = S0;
    y = 1'b0;
    case (state_q)
      S0: state_d = x ? S1 : S0;
      S1: state_d = x ? S2 : S0;
      S2: state_d = x ? S2 : S3;
      S3: state_d = x ? S4 : S0;
      S4: y = x & ~rst;
      default: state_d = S0;
    endcase
  end
  // state register with synchronous reset
  always_ff @(posedge clk) state_q <= rst ? S0 : state_d;
endmodule

// File: tb/tb_mealy_nonlap_11011_detector.sv
// tb_mealy_nonlap_11011_detector: directed checks of the 11011 non-overlapping detector
module tb_mealy_nonlap_11011_detector;
  logic clk = 1'b0;
  logic rst, x, y;
  int checks = 0;
  int failures = 0;
  mealy_nonlap_11011_detector dut (.clk(clk), .rst(rst), .x(x), .y(y));
  always #5 clk = ~clk;
  // apply one bit, check y before the consuming edge, then advance past the edge
  task automatic step(input logic r, input logic b, input logic e, input string tag, input int idx);
    rst = r;
    x = b;
    #1;
    checks++;
    assert (y === e) else begin
      failures++;
      $error("FAIL %s[%0d] y=%b expected=%b", tag, idx, y, e);
    end
    @(posedge clk);
    #1;
  endtask
  // feed n bits MSB-first with matching expected strobes
  task automatic run(input logic [31:0] bits, input logic [31:0] exp, input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, bits[n-1-i], exp[n-1-i], tag, i);
  endtask
  initial begin
    rst = 1'b1;
    x = 1'b1;
    step(1'b1, 1'b1, 1'b0, "reset", 0);
    step(1'b1, 1'b1, 1'b0, "reset", 1);
    run(32'b00101110110101110111, 32'b00000000010000000010, 20, "ref_stream");
    step(1'b1, 1'b0, 1'b0, "sep", 0);
    run(32'b11011011, 32'b00001000, 8, "overlap");
    step(1'b1, 1'b0, 1'b0, "sep", 1);
    run(32'b1111011, 32'b0000001, 7, "lead_ones");
    step(1'b1, 1'b0, 1'b0, "sep", 2);
    run(32'b110011, 32'b000000, 6, "near_miss_a");
    run(32'b011, 32'b001, 3, "s2_hold");
    step(1'b1, 1'b0, 1'b0, "sep", 3);
    run(32'b11010, 32'b00000, 5, "near_miss_b");
    run(32'b11011, 32'b00001, 5, "probe_s0");
    step(1'b1, 1'b0, 1'b0, "sep", 4);
    run(32'b1101, 32'b0000, 4, "pre_rst");
    step(1'b1, 1'b1, 1'b0, "rst_in_s4", 0);
    run(32'b11011, 32'b00001, 5, "post_rst");
    run(32'b1, 32'b0, 1, "tail");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mealy_nonlap_11011_detector.md
Name: mealy_nonlap_11011_detector

Overview:
Serial bit-stream pattern detector. It samples one input bit per clock and flags every non-overlapping occurrence of the sequence 1-1-0-1-1, in arrival order. The output is Mealy: it depends on the current state and the current input bit. It is a small control-path block, fed by a serial data source, that drives a single-cycle detect strobe to downstream logic.

Parameters:
None. The pattern 11011 and the non-overlapping policy are fixed.

Ports:
clk  input  1  system clock; all state updates occur on the rising edge
rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk
x    input  1  serial data bit, one bit consumed per rising edge
y    output 1  detect strobe; 1 when the bit currently on x completes 11011

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst): on a rising edge with rst=1, the state goes to S0, regardless of x.
- y is forced to 0 whenever rst=1.
- States, named by the prefix matched so far:
  - S0: nothing matched (reset/idle)
  - S1: "1"
  - S2: "11"
  - S3: "110"
  - S4: "1101"
- Transitions on a rising edge with rst=0 (x=0 / x=1):
  - S0: x=0 -> S0; x=1 -> S1
  - S1: x=0 -> S0; x=1 -> S2
  - S2: x=0 -> S3; x=1 -> S2 (extra leading 1s keep the "11" prefix)
  - S3: x=0 -> S0; x=1 -> S4
  - S4: x=0 -> S0; x=1 -> S0 with detection
- Output (combinational, Mealy):
  - y = 1 exactly when state = S4, x = 1 and rst = 0; otherwise y = 0.
  - y is valid after x settles and before the rising edge that consumes that bit.
  - Latency: zero cycles from the final 1 of the pattern. y lasts one bit period when x is held stable for a full cycle.
- Non-overlapping policy: after a detection, matching restarts from S0. No bit of a detected pattern is reused, so the trailing "11" does not count as a new prefix.
- Unknown/illegal state encodings (if a binary encoding is used) go to S0 on the next edge with y=0.
- Reset mid-sequence: the partial match is discarded. A pattern that straddles the reset edge is not detected.
- Implementation: a registered state plus a combinational next-state/output block. Any state encoding is acceptable; no latches are allowed.

Test Plan:
1. Reset: hold rst=1 for one edge with x=1, then release -> y=0 throughout reset; the first bit after release is evaluated from S0.
2. Reference stream, 20 bits applied first to last, one per clock, x stable across each rising edge: 0,0,1,0,1,1,1,0,1,1,0,1,0,1,1,1,0,1,1,1 -> y=1 only during bit indices 9 and 18 (0-based); y=0 for all other bits.
3. Overlap rejection: stream 1,1,0,1,1,0,1,1 -> y=1 only at index 4. No strobe at index 7, because the pattern does not reuse bits.
4. Leading-ones tolerance: stream 1,1,1,1,0,1,1 -> y=1 only at index 6, via the S2 self-loop.
5. Near misses: streams 1,1,0,0,1,1 and 1,1,0,1,0 -> y stays 0, and the state returns to S0 after each failing bit.
6. Reset during S4: feed 1,1,0,1, then assert rst=1 with x=1 -> y=0 and the state is S0. Then release rst and feed 1,1,0,1,1 -> y=1 only on the fifth bit.
